spi_slave_bus: RTL and testbench
================================

Name: spi_slave_bus

Overview:
- Parametrised next-generation SPI slave (SPI mode 0) running entirely in the system clock domain. sclk, csz and sdi are oversampled.
- Decodes frames of the form [address | R/W | data] and issues single-cycle read/write strobes on a generic memory bus. That bus replaces the hard-wired internal memory instance.
- Adds configurable address/data widths, burst auto-increment and framing-error detection.

Parameters:
- ADDR_W, 7: address bits per frame, MSB first.
- DATA_W, 16: data bits per word, MSB first.
- BURST_EN, 1: 1 = auto-increment address across consecutive words while csz stays low; 0 = single word per frame.
- SYNC_STAGES, 2: synchroniser depth on sclk/csz/sdi (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- reset  in  1  synchronous, active-high reset.
- sclk  in  1  SPI serial clock from master; asynchronous; idles low.
- csz  in  1  chip select, active low; asynchronous.
- sdi  in  1  serial data from master.
- sdo  out  1  serial data to master.
- sdo_oe  out  1  output enable for the sdo pad driver.
- mem_addr  out  ADDR_W  bus address.
- mem_we  out  1  one-cycle write strobe.
- mem_wdata  out  DATA_W  write data, valid while mem_we is high.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  DATA_W  read data, valid exactly 1 clk after mem_re.
- busy  out  1  high while a frame is in progress.
- frame_err  out  1  one-cycle pulse when a frame is aborted mid-field.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. All state updates on posedge clk only.
- Reset values: sdo=1, sdo_oe=0, mem_addr=0, mem_we=0, mem_wdata=0, mem_re=0, busy=0, frame_err=0, state=IDLE, bit counter=0.
- Input conditioning:
  - sclk, csz and sdi each pass through SYNC_STAGES flops.
  - sclk_rise / sclk_fall are single-cycle pulses derived from the synchronised sclk and its 1-cycle delay.
- Sampling: sdi is sampled on sclk_rise; sdo changes only on sclk_fall (mode 0).
- Bit counter width: $clog2(max(ADDR_W,DATA_W)+1). It resets to 0 on every field change.
- States:
  - IDLE: sdo=1, sdo_oe=0, busy=0. Synced csz falling -> ADDR, busy=1.
  - ADDR: shift sdi into the address register on each sclk_rise. After ADDR_W bits -> RW.
  - RW: the next sclk_rise samples the R/W bit (1 = read).
    - Read: mem_re pulses on the following clk with mem_addr = address. Next state DATA_RD.
    - Write: next state DATA_WR.
  - DATA_RD:
    - One clk after mem_re, mem_rdata is captured into a hold register.
    - On the first sclk_fall of the word: sdo = hold[DATA_W-1], and the shift register is loaded with hold<<1.
    - Each later sclk_fall shifts the next bit out.
    - sdo_oe=1 throughout DATA_RD.
  - DATA_WR: shift sdi in on each sclk_rise.
  - Word end (DATA_W-th sclk_rise):
    - Write: mem_we pulses the next clk with mem_wdata = shift register and mem_addr = current address.
    - BURST_EN=1: address increments modulo 2^ADDR_W. A read also pulses mem_re for the new address on the same clk. Stay in DATA_RD/DATA_WR.
    - BURST_EN=0: -> DONE.
  - DONE: sclk edges ignored, sdo=1, sdo_oe=0. Synced csz high -> IDLE.
- Abort (synced csz rises in any non-IDLE state):
  - Go to IDLE on the next clk. busy=0, sdo_oe=0, sdo=1.
  - A partial write word is discarded: no mem_we.
  - frame_err pulses 1 clk if the abort lands in ADDR, RW, or a data state with bit counter ≠ 0.
  - No frame_err on a clean word boundary or in DONE.
- Simultaneity:
  - A csz rise on the same clk as a word-end sclk_rise completes the word first: mem_we is still issued, then IDLE.
  - reset overrides everything.
- Reset mid-frame: the next clk shows reset values. The block waits for csz high, then low, before accepting a new frame. csz held low at reset release does not start a frame.
- mem_we and mem_re are never high on the same clk.

Decomposition:
- Package spi_slave_pkg holds:
  - enum state_t {IDLE, ADDR, RW, DATA_RD, DATA_WR, DONE}
  - constant RW_READ = 1'b1
  - localparam function clog2max for the counter width.
- Sub-module spi_sync_edge (parameter SYNC_STAGES): multi-flop synchroniser plus rise/fall pulse outputs. Instantiated for sclk and csz; sdi uses the synchroniser only.

Test Plan:
All scenarios use ADDR_W=7, DATA_W=16, sclk = clk/8.
- Write addr 0x15, data 0xA5C3, then csz high -> exactly one mem_we, mem_addr=0x15, mem_wdata=0xA5C3; frame_err=0.
- Read addr 0x15, bus model returns 0xA5C3 -> one mem_re with mem_addr=0x15; sdo sampled on sclk rises = 1010_0101_1100_0011; sdo_oe high only during data.
- Burst write at 0x7F, words 0x1111/0x2222/0x3333 -> mem_we at addresses 0x7F, 0x00, 0x01 with matching data (address wrap). BURST_EN=0 run -> only 0x7F written; extra clocks ignored.
- Burst read at 0x10, two words, model returns addr*0x0101 -> sdo streams 0x1010 then 0x1111; mem_re at 0x10 then 0x11.
- Write frame, csz raised after 9 data bits -> no mem_we, frame_err one clk; the next full write to 0x02 (data 0xBEEF) completes correctly.
- reset asserted during the 5th bit of a read -> next clk shows all reset values; the following frame works only after a csz high/low cycle.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: state encoding and sizing helper shared by the SPI slave files
package spi_slave_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, RW, DATA_RD, DATA_WR, DONE} state_t;
  localparam logic RW_READ = 1'b1;
  function automatic int clog2max(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with single-cycle rise/fall pulses
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  // clearing to 0 means a csz held low through reset never looks like a falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      prev <= sync[SYNC_STAGES-1];
    end
  end
  assign rise = sync[SYNC_STAGES-1] & ~prev;
  assign fall = ~sync[SYNC_STAGES-1] & prev;
endmodule

// File: rtl/spi_slave_bus.sv
// spi_slave_bus: mode-0 SPI slave decoding [addr | R/W | data] frames onto a strobe memory bus
module spi_slave_bus
  import spi_slave_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 16,
  parameter bit BURST_EN    = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              csz,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              frame_err
);
  localparam int CW = clog2max(ADDR_W, DATA_W);
  state_t state;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] shreg, hold, shift_in;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic sdi_s, sclk_rise, sclk_fall, csz_rise, csz_fall, re_d;
  logic in_data, addr_last, word_end, mid_word;
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .reset(reset), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csz (
    .clk(clk), .reset(reset), .din(csz), .rise(csz_rise), .fall(csz_fall)
  );
  always_ff @(posedge clk) begin
    if (reset) sdi_sync <= '0;
    else sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
  end
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign shift_in  = {shreg[DATA_W-2:0], sdi_s};
  assign in_data   = state == DATA_RD || state == DATA_WR;
  assign addr_last = sclk_rise && cnt == CW'(ADDR_W - 1);
  assign word_end  = in_data && sclk_rise && cnt == CW'(DATA_W - 1);
  assign mid_word  = (cnt != '0 || sclk_rise) && !word_end;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      shreg     <= '0;
      hold      <= '0;
      re_d      <= 1'b0;
      sdo       <= 1'b1;
      sdo_oe    <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      frame_err <= 1'b0;
      re_d      <= mem_re;
      if (re_d) hold <= mem_rdata;
      // a word completing on the same clk as csz rising is still written
      if (state != IDLE && csz_rise) begin
        if (state == DATA_WR && word_end) begin
          mem_we    <= 1'b1;
          mem_wdata <= shift_in;
          mem_addr  <= addr;
        end
        frame_err <= state == ADDR || state == RW || (in_data && mid_word);
        state     <= IDLE;
        cnt       <= '0;
        busy      <= 1'b0;
        sdo       <= 1'b1;
        sdo_oe    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (csz_fall) begin
            state <= ADDR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
          ADDR: if (sclk_rise) begin
            addr <= {addr[ADDR_W-2:0], sdi_s};
            cnt  <= addr_last ? '0 : cnt + 1'b1;
            if (addr_last) state <= RW;
          end
          RW: if (sclk_rise) begin
            if (sdi_s == RW_READ) begin
              state    <= DATA_RD;
              sdo_oe   <= 1'b1;
              mem_re   <= 1'b1;
              mem_addr <= addr;
            end else state <= DATA_WR;
          end
          DATA_WR: if (sclk_rise) begin
            shreg <= shift_in;
            cnt   <= word_end ? '0 : cnt + 1'b1;
            if (word_end) begin
              mem_we    <= 1'b1;
              mem_wdata <= shift_in;
              mem_addr  <= addr;
              if (BURST_EN) addr <= addr + 1'b1;
              else state <= DONE;
            end
          end
          DATA_RD: begin
            // the first fall of each word takes its MSB from the freshly captured hold register
            if (sclk_fall) begin
              sdo   <= cnt == '0 ? hold[DATA_W-1] : shreg[DATA_W-1];
              shreg <= (cnt == '0 ? hold : shreg) << 1;
            end
            if (sclk_rise) begin
              cnt <= word_end ? '0 : cnt + 1'b1;
              if (word_end && BURST_EN) begin
                addr     <= addr + 1'b1;
                mem_re   <= 1'b1;
                mem_addr <= addr + 1'b1;
              end else if (word_end) begin
                state  <= DONE;
                sdo    <= 1'b1;
                sdo_oe <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_bus.sv
// tb_spi_slave_bus: SPI master driving a burst and a single-word slave, checked against a frame-level model
module tb_spi_slave_bus;
  localparam int AW = 7;
  localparam int DW = 16;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;
  logic clk = 1'b0, reset = 1'b1, sclk = 1'b0, csz = 1'b1, sdi = 1'b0, init = 1'b1;
  logic [1:0] sdo, sdo_oe, mem_we, mem_re, busy, frame_err, rd_v;
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2], mem_rdata [2], rd_d [2];
  logic [DW-1:0] bus_mem [2][128];
  logic [DW-1:0] model_mem [2][128];
  logic [DW-1:0] words [4], rx [4];
  ev_t expq [2][$];
  int err_seen [2];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  spi_slave_bus #(.ADDR_W(AW), .DATA_W(DW), .BURST_EN(1'b1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .csz(csz), .sdi(sdi), .sdo(sdo[0]), .sdo_oe(sdo_oe[0]),
    .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]), .mem_re(mem_re[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .frame_err(frame_err[0])
  );
  spi_slave_bus #(.ADDR_W(AW), .DATA_W(DW), .BURST_EN(1'b0), .SYNC_STAGES(2)) dut_nb (
    .clk(clk), .reset(reset), .sclk(sclk), .csz(csz), .sdi(sdi), .sdo(sdo[1]), .sdo_oe(sdo_oe[1]),
    .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]), .mem_re(mem_re[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .frame_err(frame_err[1])
  );

  // bus memory responder: read data valid exactly one clk after mem_re, junk otherwise
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (init) for (int a = 0; a < 128; a++) bus_mem[i][a] <= DW'(a) * 16'h0101;
      else if (mem_we[i]) bus_mem[i][mem_addr[i]] <= mem_wdata[i];
      rd_v[i] <= mem_re[i];
      rd_d[i] <= bus_mem[i][mem_addr[i]];
    end
  assign mem_rdata[0] = rd_v[0] ? rd_d[0] : 16'hDEAD;
  assign mem_rdata[1] = rd_v[1] ? rd_d[1] : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, ex);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_reset_vals%0d", tag, i),
          {sdo[i], sdo_oe[i], mem_addr[i], mem_we[i], mem_wdata[i], mem_re[i], busy[i], frame_err[i]},
          {1'b1, 28'b0});
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset)
        for (int i = 0; i < 2; i++) begin
          if (frame_err[i]) err_seen[i]++;
          chk($sformatf("we_re_exclusive%0d", i), {31'b0, mem_we[i] & mem_re[i]}, 0);
          if (mem_we[i] || mem_re[i]) begin
            if (expq[i].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_strobe%0d: got we=%b re=%b addr=%h, expected no strobe",
                       i, mem_we[i], mem_re[i], mem_addr[i]);
            end else begin
              e = expq[i].pop_front();
              chk($sformatf("strobe_kind%0d", i), {31'b0, mem_we[i]}, {31'b0, e.we});
              chk($sformatf("strobe_addr%0d", i), 32'(mem_addr[i]), 32'(e.addr));
              if (e.we) chk($sformatf("strobe_wdata%0d", i), 32'(mem_wdata[i]), 32'(e.data));
            end
          end
        end
    end
  endtask

  // lim: bits sent before csz rises (-1 = whole frame); rst_at: bit during which reset pulses (-1 = none)
  task automatic frame(input logic [AW-1:0] a, input logic rw, input int nw, input int lim, input int rst_at);
    int total, nb, cw, nev, k;
    int exp_err [2];
    logic [1:0] ex;
    bit in_rst;
    ev_t e;
    total = 8 + 16 * nw;
    nb = (lim < 0 || lim > total) ? total : lim;
    for (int i = 0; i < 2; i++) begin
      cw = nb >= 8 ? (nb - 8) / 16 : 0;
      if (i == 1 && cw > 1) cw = 1;
      if (rst_at >= 0) cw = 0;
      if (rw) begin
        nev = nb < 8 ? 0 : (i == 1 || rst_at >= 0) ? 1 : cw + 1;
        for (int j = 0; j < nev; j++) begin
          e.we = 1'b0;
          e.addr = a + AW'(j);
          e.data = '0;
          expq[i].push_back(e);
        end
      end else
        for (int j = 0; j < cw; j++) begin
          e.we = 1'b1;
          e.addr = a + AW'(j);
          e.data = words[j];
          expq[i].push_back(e);
          model_mem[i][e.addr] = words[j];
        end
      exp_err[i] = (rst_at < 0 && (nb < 8 || ((nb - 8) % 16 != 0 && !(i == 1 && nb >= 24)))) ? 1 : 0;
      err_seen[i] = 0;
    end
    in_rst = 0;
    csz = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      k = b - 8;
      if (b < AW) sdi = a[AW-1-b];
      else if (b == AW) sdi = rw;
      else if (rw) sdi = 1'($urandom);
      else sdi = words[k / 16][15 - k % 16];
      repeat (4) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ex = 2'b10;
        if (!in_rst && rw && k >= 0 && (i == 0 || k < 16))
          ex = {model_mem[i][a + AW'(k / 16)][15 - k % 16], 1'b1};
        chk($sformatf("sdo_oe_bit%0d_dut%0d", b, i), {30'b0, sdo[i], sdo_oe[i]}, {30'b0, ex});
        if (in_rst) chk($sformatf("busy_after_reset%0d", i), {31'b0, busy[i]}, 0);
      end
      if (rw && k >= 0) rx[k / 16][15 - k % 16] = sdo[0];
      sclk = 1'b1;
      if (b == rst_at) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("mid_frame");
        in_rst = 1;
      end
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    csz = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("missing_strobes%0d", i), expq[i].size(), 0);
      expq[i].delete();
      chk($sformatf("frame_err_count%0d", i), err_seen[i], exp_err[i]);
      chk($sformatf("idle_outputs%0d", i), {29'b0, busy[i], sdo_oe[i], sdo[i]}, 32'b001);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 128; a++) model_mem[i][a] = DW'(a) * 16'h0101;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    init = 1'b0;
    reset = 1'b0;
    fork
      monitor();
    join_none
    repeat (6) @(negedge clk);
    words[0] = 16'hA5C3;
    frame(7'h15, 1'b0, 1, -1, -1);
    frame(7'h15, 1'b1, 1, -1, -1);
    chk("read_0x15_literal", 32'(rx[0]), 32'hA5C3);
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    frame(7'h7F, 1'b0, 3, -1, -1);
    chk("burst_wrap_0x00", 32'(bus_mem[0][0]), 32'h2222);
    chk("burst_0x01", 32'(bus_mem[0][1]), 32'h3333);
    chk("single_0x7f", 32'(bus_mem[1][127]), 32'h1111);
    chk("single_no_0x00", 32'(bus_mem[1][0]), 32'h0000);
    frame(7'h10, 1'b1, 2, -1, -1);
    chk("burst_rd_w0_literal", 32'(rx[0]), 32'h1010);
    chk("burst_rd_w1_literal", 32'(rx[1]), 32'h1111);
    words[0] = 16'h5A5A;
    frame(7'h33, 1'b0, 1, 17, -1);
    chk("aborted_not_written", 32'(bus_mem[0][51]), 32'h3333);
    words[0] = 16'hBEEF;
    frame(7'h02, 1'b0, 1, -1, -1);
    chk("after_abort_0x02", 32'(bus_mem[0][2]), 32'hBEEF);
    frame(7'h15, 1'b1, 1, -1, 12);
    frame(7'h02, 1'b1, 1, -1, -1);
    chk("read_after_reset_literal", 32'(rx[0]), 32'hBEEF);
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] ra;
      logic rrw;
      int nw, lim;
      ra = AW'($urandom);
      rrw = 1'($urandom);
      nw = $urandom_range(1, 3);
      lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8 + 16 * nw) : -1;
      for (int j = 0; j < 4; j++) words[j] = DW'($urandom);
      frame(ra, rrw, nw, lim, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
